// File: rtl/shared_bank_allocator_gen_if.sv
// Bus bundle between the router core and one shared-bank allocator.
// master: router side (drives occupancy/status, receives grant/ready).
// slave : allocator side.
interface shared_bank_allocator_gen_if #(
    parameter int num_vcs       = 5,
    parameter int num_ports     = 5,
    parameter int fb_addr_width = 6
);
    localparam int num_vcs_per_bank = num_vcs / num_ports;

    logic [num_ports*fb_addr_width-1:0] flit_count_ip;
    logic [num_ports*num_vcs-1:0]       fb_empty_ivc;
    logic [num_ports*num_vcs-1:0]       allocated_ip_shared_ivc;
    logic [num_vcs_per_bank-1:0]        shared_ivc_empty;
    logic [num_ports-1:0]               candidate_mask;
    logic [num_ports-1:0]               memory_bank_grant_out;
    logic                               ready_for_allocation;
    logic                               realloc_abort;

    modport master (
        output flit_count_ip, fb_empty_ivc, allocated_ip_shared_ivc,
               shared_ivc_empty, candidate_mask,
        input  memory_bank_grant_out, ready_for_allocation, realloc_abort
    );

    modport slave (
        input  flit_count_ip, fb_empty_ivc, allocated_ip_shared_ivc,
               shared_ivc_empty, candidate_mask,
        output memory_bank_grant_out, ready_for_allocation, realloc_abort
    );
endinterface

// File: rtl/shared_bank_allocator_gen.sv
// Shared memory bank ownership allocator (one instance per bank).
// Picks the most loaded congested eligible port, drains the bank's shared
// VCs, then hands ownership to that port. A hold window after every switch
// prevents ownership from bouncing between ports.
// Optional: define DRAIN_TIMEOUT_EN to abandon a drain that takes longer
// than drain_timeout cycles (pulses realloc_abort).
// Grant vector is one-hot with the MSB representing port 0.
module shared_bank_allocator_gen #(
    parameter int num_vcs       = 5,
    parameter int num_ports     = 5,
    parameter int bank_id       = 0,
    parameter int threshold     = 4,
    parameter int fb_addr_width = 6,
    parameter int min_hold      = 16,
    parameter int drain_timeout = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    shared_bank_allocator_gen_if.slave   bus
);
    localparam int num_vcs_per_bank = num_vcs / num_ports;
    localparam int PORT_W = (num_ports > 1) ? $clog2(num_ports) : 1;
    localparam int HOLD_W = (min_hold > 0) ? $clog2(min_hold + 1) : 1;
    localparam logic [PORT_W-1:0]        HOME_PORT  = PORT_W'(bank_id);
    localparam logic [HOLD_W-1:0]        HOLD_LOAD  = HOLD_W'(min_hold);
    localparam logic [fb_addr_width-1:0] FB_THRESH  = fb_addr_width'(threshold);

    typedef enum logic [1:0] {
        ST_IDLE_BAD = 2'b00,
        ST_ENABLE   = 2'b01,
        ST_DRAIN    = 2'b10,
        ST_SWITCH   = 2'b11
    } state_e;

    // One-hot grant for a port index, port 0 on the MSB.
    function automatic logic [num_ports-1:0] port_onehot(input logic [PORT_W-1:0] p);
        logic [num_ports-1:0] oh;
        oh = '0;
        oh[num_ports-1-int'(p)] = 1'b1;
        return oh;
    endfunction

    state_e                  state_q, state_d;
    logic [num_ports-1:0]    grant_q, grant_d;
    logic [PORT_W-1:0]       owner_q, owner_d;
    logic [PORT_W-1:0]       target_q, target_d;
    logic [num_ports-1:0]    cong_old_q, cong_old_d;
    logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic                    ready_q, ready_d;

    logic [num_ports-1:0]     cong_s;
    logic [PORT_W-1:0]        winner_s;
    logic [fb_addr_width-1:0] win_cnt_s;
    logic [fb_addr_width-1:0] cnt_s;
    logic                     win_found_s;
    logic                     bank_busy_s;
    logic                     drained_s;
    logic                     trigger_s;

`ifdef DRAIN_TIMEOUT_EN
    localparam int DRAIN_W    = (drain_timeout > 0) ? $clog2(drain_timeout + 1) : 1;
    localparam int DRAIN_LAST = (drain_timeout > 0) ? drain_timeout - 1 : 0;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic               abort_q, abort_d;
`endif

    // Per-port congestion flags and the most loaded congested port (lowest index on ties).
    always_comb begin
        cong_s      = '0;
        winner_s    = owner_q;
        win_cnt_s   = '0;
        win_found_s = 1'b0;
        cnt_s       = '0;
        for (int ip = 0; ip < num_ports; ip++) begin
            cnt_s      = bus.flit_count_ip[ip*fb_addr_width +: fb_addr_width];
            cong_s[ip] = (cnt_s >= FB_THRESH) &&
                         !(|bus.fb_empty_ivc[ip*num_vcs +: num_vcs]) &&
                         bus.candidate_mask[ip];
            if (cong_s[ip] && (!win_found_s || (cnt_s > win_cnt_s))) begin
                winner_s    = PORT_W'(ip);
                win_cnt_s   = cnt_s;
                win_found_s = 1'b1;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Any port still holding one of this bank's VCs keeps the bank busy.
    always_comb begin
        bank_busy_s = 1'b0;
        for (int i = 0; i < num_ports*num_vcs; i++) begin
            bank_busy_s = bank_busy_s |
                (bus.allocated_ip_shared_ivc[i] & (((i % num_vcs) / num_vcs_per_bank) == bank_id));
        end
    end

    assign drained_s = !bank_busy_s && (&bus.shared_ivc_empty);
    assign trigger_s = (state_q == ST_ENABLE) && (hold_cnt_q == '0) && (|cong_s) &&
                       (cong_s != cong_old_q) && (winner_s != owner_q);

    // Next-state and next-output computation for the ownership FSM.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        target_d   = target_q;
        cong_old_d = cong_old_q;
        hold_cnt_d = hold_cnt_q;
        ready_d    = ready_q;
`ifdef DRAIN_TIMEOUT_EN
        drain_cnt_d = drain_cnt_q;
        abort_d     = 1'b0;
`endif
        case (state_q)
            ST_ENABLE: begin
                if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q;
                end
                if (trigger_s) begin
                    cong_old_d = cong_s;
                    target_d   = winner_s;
                    state_d    = ST_DRAIN;
                    ready_d    = 1'b0;
`ifdef DRAIN_TIMEOUT_EN
                    drain_cnt_d = '0;
`endif
                end else if ((cong_s != cong_old_q) && (winner_s == owner_q)) begin
                    cong_old_d = cong_s;
                end else begin
                    cong_old_d = cong_old_q;
                end
            end
            ST_DRAIN: begin
                ready_d = 1'b0;
                if (drained_s) begin
                    state_d = ST_SWITCH;
                end
`ifdef DRAIN_TIMEOUT_EN
                else if (drain_cnt_q == DRAIN_W'(DRAIN_LAST)) begin
                    state_d    = ST_ENABLE;
                    ready_d    = 1'b1;
                    abort_d    = 1'b1;
                    hold_cnt_d = HOLD_LOAD;
                    cong_old_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
`else
                else begin
                    state_d = ST_DRAIN;
                end
`endif
            end
            ST_SWITCH: begin
                owner_d    = target_q;
                grant_d    = port_onehot(target_q);
                ready_d    = 1'b1;
                hold_cnt_d = HOLD_LOAD;
                state_d    = ST_ENABLE;
            end
            default: begin
                // Illegal encoding: fall back to reset values, keep congestion history.
                state_d    = ST_ENABLE;
                owner_d    = HOME_PORT;
                grant_d    = port_onehot(HOME_PORT);
                target_d   = HOME_PORT;
                hold_cnt_d = '0;
                ready_d    = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ENABLE;
            grant_q    <= port_onehot(HOME_PORT);
            owner_q    <= HOME_PORT;
            target_q   <= HOME_PORT;
            cong_old_q <= '0;
            hold_cnt_q <= '0;
            ready_q    <= 1'b1;
`ifdef DRAIN_TIMEOUT_EN
            drain_cnt_q <= '0;
            abort_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            target_q   <= target_d;
            cong_old_q <= cong_old_d;
            hold_cnt_q <= hold_cnt_d;
            ready_q    <= ready_d;
`ifdef DRAIN_TIMEOUT_EN
            drain_cnt_q <= drain_cnt_d;
            abort_q     <= abort_d;
`endif
        end
    end

    assign bus.memory_bank_grant_out = grant_q;
    assign bus.ready_for_allocation  = ready_q;
`ifdef DRAIN_TIMEOUT_EN
    assign bus.realloc_abort = abort_q;
`else
    assign bus.realloc_abort = 1'b0;
`endif

endmodule

// File: tb/tb_shared_bank_allocator_gen.sv
// Directed bench for shared_bank_allocator_gen: bank 2 of a 5-port router,
// 5 VCs per port (one VC per bank), threshold 4, hold 16, drain timeout 8.
module tb_shared_bank_allocator_gen;
    localparam int NP = 5;
    localparam int NV = 5;
    localparam int FW = 6;
    localparam int BANK = 2;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    shared_bank_allocator_gen_if #(.num_vcs(NV), .num_ports(NP), .fb_addr_width(FW)) bus_if ();

    shared_bank_allocator_gen #(
        .num_vcs(NV), .num_ports(NP), .bank_id(BANK), .threshold(4),
        .fb_addr_width(FW), .min_hold(16), .drain_timeout(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and log mismatches.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and step 1ns past it.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Set a port's occupancy; busy=1 makes every VC of that port non-empty.
    task automatic set_port(input int p, input int cnt, input bit busy);
        bus_if.flit_count_ip[p*FW +: FW] = FW'(cnt);
        bus_if.fb_empty_ivc[p*NV +: NV]  = busy ? 5'b00000 : 5'b11111;
    endtask

    task automatic clear_ports();
        for (int p = 0; p < NP; p++) set_port(p, 0, 1'b0);
    endtask

    task automatic check_out(input string tag, input logic [4:0] g, input logic r);
        check_val({tag, "_grant"}, {27'd0, bus_if.memory_bank_grant_out}, {27'd0, g});
        check_val({tag, "_ready"}, {31'd0, bus_if.ready_for_allocation}, {31'd0, r});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b1;
        bus_if.flit_count_ip           = '0;
        bus_if.fb_empty_ivc            = '1;
        bus_if.allocated_ip_shared_ivc = '0;
        bus_if.shared_ivc_empty        = 1'b1;
        bus_if.candidate_mask          = 5'b11111;
        tick(2);
        check_out("rst", 5'b00100, 1'b1);
        check_val("rst_abort", {31'd0, bus_if.realloc_abort}, 32'd0);
        reset = 1'b0;
        tick(2);
        check_out("idle", 5'b00100, 1'b1);

        // Ports 1 and 3 tie at 7: lowest index wins.
        set_port(1, 7, 1'b1);
        set_port(3, 7, 1'b1);
        tick(1);
        check_out("tie_T", 5'b00100, 1'b0);
        tick(1);
        check_out("tie_T1", 5'b00100, 1'b0);
        tick(1);
        check_out("tie_T2", 5'b01000, 1'b1);

        // After the hold, counts 6 and 9: port 3 wins.
        clear_ports();
        tick(18);
        set_port(1, 6, 1'b1);
        set_port(3, 9, 1'b1);
        tick(1);
        check_out("max_T", 5'b01000, 1'b0);
        tick(2);
        check_out("max_T2", 5'b00010, 1'b1);

        // Hold window: port 0 congests 3 cycles after the switch.
        clear_ports();
        tick(3);
        set_port(0, 5, 1'b1);
        tick(12);
        check_out("hold_15", 5'b00010, 1'b1);
        tick(1);
        check_out("hold_16", 5'b00010, 1'b1);
        tick(1);
        check_out("hold_17", 5'b00010, 1'b0);
        tick(2);
        check_out("hold_19", 5'b10000, 1'b1);

        // Port 4 congests while port 2's bank VC stays allocated.
        clear_ports();
        tick(18);
        bus_if.allocated_ip_shared_ivc[2*NV + BANK] = 1'b1;
        set_port(4, 8, 1'b1);
        tick(1);
        check_out("blk_T", 5'b10000, 1'b0);
        tick(9);
        check_out("blk_T10", 5'b10000, 1'b0);
        bus_if.allocated_ip_shared_ivc[2*NV + BANK] = 1'b0;
        tick(1);
        check_out("blk_T11", 5'b10000, 1'b0);
        tick(1);
        check_out("blk_T12", 5'b00001, 1'b1);

        // Masked port 3 and below-threshold port 1 must not trigger.
        clear_ports();
        tick(18);
        bus_if.candidate_mask = 5'b10111;
        set_port(3, 10, 1'b1);
        set_port(1, 3, 1'b1);
        tick(4);
        check_out("mask", 5'b00001, 1'b1);
        set_port(1, 4, 1'b1);
        tick(1);
        check_out("thr_T", 5'b00001, 1'b0);
        tick(2);
        check_out("thr_T2", 5'b01000, 1'b1);
        // Removing the owner from the mask does not revoke its grant.
        bus_if.candidate_mask = 5'b11101;
        tick(3);
        check_out("revoke", 5'b01000, 1'b1);
        clear_ports();
        bus_if.candidate_mask = 5'b11111;

        // Drain that never completes.
        tick(18);
        bus_if.shared_ivc_empty = 1'b0;
        set_port(0, 5, 1'b1);
        tick(1);
        check_out("stuck_T", 5'b01000, 1'b0);
`ifdef DRAIN_TIMEOUT_EN
        tick(7);
        check_out("to_T7", 5'b01000, 1'b0);
        check_val("to_T7_abort", {31'd0, bus_if.realloc_abort}, 32'd0);
        tick(1);
        check_out("to_T8", 5'b01000, 1'b1);
        check_val("to_T8_abort", {31'd0, bus_if.realloc_abort}, 32'd1);
        tick(1);
        check_val("to_T9_abort", {31'd0, bus_if.realloc_abort}, 32'd0);
`else
        tick(20);
        check_out("stuck_T20", 5'b01000, 1'b0);
        check_val("stuck_abort", {31'd0, bus_if.realloc_abort}, 32'd0);
`endif

        // Make sure we are mid-drain, then reset for 3 cycles.
        for (int k = 0; k < 40; k++) begin
            if (bus_if.ready_for_allocation == 1'b0) break;
            tick(1);
        end
        check_val("redrain_ready", {31'd0, bus_if.ready_for_allocation}, 32'd0);
        reset = 1'b1;
        tick(3);
        check_out("rst_mid", 5'b00100, 1'b1);
        check_val("rst_mid_abort", {31'd0, bus_if.realloc_abort}, 32'd0);
        reset = 1'b0;
        clear_ports();
        bus_if.shared_ivc_empty = 1'b1;
        tick(1);
        check_out("post_rst", 5'b00100, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
